// File: rtl/wb_ic_2x2.sv
// Two-master, two-slave Wishbone classic interconnect: address decode,
// per-slave round-robin grant, and error termination of unmapped accesses.
//
// state  | meaning
// IDLE   | slave free, all slave-side outputs held at 0
// M0     | slave bound to master 0 until m0_cyc drops
// M1     | slave bound to master 1 until m1_cyc drops
module wb_ic_2x2 #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] SLAVE0_ADDR_BASE  = 'h0000_0000,
  parameter logic [WB_ADDR_WIDTH-1:0] SLAVE0_ADDR_LIMIT = 'h0000_1fff,
  parameter logic [WB_ADDR_WIDTH-1:0] SLAVE1_ADDR_BASE  = 'h1000_0000,
  parameter logic [WB_ADDR_WIDTH-1:0] SLAVE1_ADDR_LIMIT = 'h1fff_ffff
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WB_ADDR_WIDTH-1:0]   m0_adr,
  input  logic [WB_DATA_WIDTH-1:0]   m0_dat_w,
  output logic [WB_DATA_WIDTH-1:0]   m0_dat_r,
  input  logic                       m0_cyc,
  input  logic                       m0_stb,
  input  logic                       m0_we,
  input  logic [WB_DATA_WIDTH/8-1:0] m0_sel,
  output logic                       m0_ack,
  output logic                       m0_err,
  input  logic [WB_ADDR_WIDTH-1:0]   m1_adr,
  input  logic [WB_DATA_WIDTH-1:0]   m1_dat_w,
  output logic [WB_DATA_WIDTH-1:0]   m1_dat_r,
  input  logic                       m1_cyc,
  input  logic                       m1_stb,
  input  logic                       m1_we,
  input  logic [WB_DATA_WIDTH/8-1:0] m1_sel,
  output logic                       m1_ack,
  output logic                       m1_err,
  output logic [WB_ADDR_WIDTH-1:0]   s0_adr,
  output logic [WB_DATA_WIDTH-1:0]   s0_dat_w,
  input  logic [WB_DATA_WIDTH-1:0]   s0_dat_r,
  output logic                       s0_cyc,
  output logic                       s0_stb,
  output logic                       s0_we,
  output logic [WB_DATA_WIDTH/8-1:0] s0_sel,
  input  logic                       s0_ack,
  input  logic                       s0_err,
  output logic [WB_ADDR_WIDTH-1:0]   s1_adr,
  output logic [WB_DATA_WIDTH-1:0]   s1_dat_w,
  input  logic [WB_DATA_WIDTH-1:0]   s1_dat_r,
  output logic                       s1_cyc,
  output logic                       s1_stb,
  output logic                       s1_we,
  output logic [WB_DATA_WIDTH/8-1:0] s1_sel,
  input  logic                       s1_ack,
  input  logic                       s1_err
);

  typedef enum logic [1:0] {G_IDLE, G_M0, G_M1} gnt_t;

  gnt_t gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic prio0_q, prio1_q;  // 1: m0 wins the next tie on that slave
  logic err0_q, err1_q;

  // Offset compare keeps the inclusive range check free of constant-zero compares.
  function automatic logic in_range(input logic [WB_ADDR_WIDTH-1:0] adr,
                                    input logic [WB_ADDR_WIDTH-1:0] base,
                                    input logic [WB_ADDR_WIDTH-1:0] limit);
    logic [WB_ADDR_WIDTH-1:0] off;
    off = adr - base;
    return off <= (limit - base);
  endfunction

  function automatic gnt_t next_gnt(input gnt_t cur, input logic r0, input logic r1,
                                    input logic prio_m0, input logic c0, input logic c1);
    gnt_t nxt;
    nxt = cur;
    case (cur)
      G_IDLE: begin
        if (r0 && (!r1 || prio_m0)) nxt = G_M0;
        else if (r1)                nxt = G_M1;
        else                        nxt = G_IDLE;
      end
      G_M0:    nxt = c0 ? G_M0 : G_IDLE;
      G_M1:    nxt = c1 ? G_M1 : G_IDLE;
      default: nxt = G_IDLE;
    endcase
    return nxt;
  endfunction

  logic m0_hit0, m0_hit1, m1_hit0, m1_hit1;
  logic m0_bound0, m0_bound1, m1_bound0, m1_bound1;
  logic m0_act, m1_act;
  logic r0_s0, r0_s1, r1_s0, r1_s1;
  logic m0_unmapped, m1_unmapped;

  assign m0_hit0 = in_range(m0_adr, SLAVE0_ADDR_BASE, SLAVE0_ADDR_LIMIT);
  assign m0_hit1 = in_range(m0_adr, SLAVE1_ADDR_BASE, SLAVE1_ADDR_LIMIT) & ~m0_hit0;
  assign m1_hit0 = in_range(m1_adr, SLAVE0_ADDR_BASE, SLAVE0_ADDR_LIMIT);
  assign m1_hit1 = in_range(m1_adr, SLAVE1_ADDR_BASE, SLAVE1_ADDR_LIMIT) & ~m1_hit0;

  assign m0_bound0 = (gnt0_q == G_M0);
  assign m0_bound1 = (gnt1_q == G_M0);
  assign m1_bound0 = (gnt0_q == G_M1);
  assign m1_bound1 = (gnt1_q == G_M1);

  assign m0_act = m0_cyc & m0_stb;
  assign m1_act = m1_cyc & m1_stb;

  // A master already holding one slave may not claim the other.
  assign r0_s0 = m0_act & m0_hit0 & ~m0_bound1;
  assign r0_s1 = m0_act & m0_hit1 & ~m0_bound0;
  assign r1_s0 = m1_act & m1_hit0 & ~m1_bound1;
  assign r1_s1 = m1_act & m1_hit1 & ~m1_bound0;

  assign m0_unmapped = m0_act & ~m0_hit0 & ~m0_hit1 & ~m0_bound0 & ~m0_bound1;
  assign m1_unmapped = m1_act & ~m1_hit0 & ~m1_hit1 & ~m1_bound0 & ~m1_bound1;

  always_comb begin
    gnt0_d = gnt0_q;
    gnt1_d = gnt1_q;
    gnt0_d = next_gnt(gnt0_q, r0_s0, r1_s0, prio0_q, m0_cyc, m1_cyc);
    gnt1_d = next_gnt(gnt1_q, r0_s1, r1_s1, prio1_q, m0_cyc, m1_cyc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0_q  <= G_IDLE;
      gnt1_q  <= G_IDLE;
      prio0_q <= 1'b1;
      prio1_q <= 1'b1;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      if (gnt0_d == G_M0)      prio0_q <= 1'b0;
      else if (gnt0_d == G_M1) prio0_q <= 1'b1;
      if (gnt1_d == G_M0)      prio1_q <= 1'b0;
      else if (gnt1_d == G_M1) prio1_q <= 1'b1;
      // Toggling gives one err per two cycles while stb is held.
      err0_q <= m0_unmapped & ~err0_q;
      err1_q <= m1_unmapped & ~err1_q;
    end
  end

  always_comb begin
    s0_adr = '0; s0_dat_w = '0; s0_cyc = 1'b0; s0_stb = 1'b0; s0_we = 1'b0; s0_sel = '0;
    case (gnt0_q)
      G_M0: begin
        s0_adr = m0_adr; s0_dat_w = m0_dat_w; s0_cyc = m0_cyc;
        s0_stb = m0_stb; s0_we = m0_we; s0_sel = m0_sel;
      end
      G_M1: begin
        s0_adr = m1_adr; s0_dat_w = m1_dat_w; s0_cyc = m1_cyc;
        s0_stb = m1_stb; s0_we = m1_we; s0_sel = m1_sel;
      end
      default: ;
    endcase
  end

  always_comb begin
    s1_adr = '0; s1_dat_w = '0; s1_cyc = 1'b0; s1_stb = 1'b0; s1_we = 1'b0; s1_sel = '0;
    case (gnt1_q)
      G_M0: begin
        s1_adr = m0_adr; s1_dat_w = m0_dat_w; s1_cyc = m0_cyc;
        s1_stb = m0_stb; s1_we = m0_we; s1_sel = m0_sel;
      end
      G_M1: begin
        s1_adr = m1_adr; s1_dat_w = m1_dat_w; s1_cyc = m1_cyc;
        s1_stb = m1_stb; s1_we = m1_we; s1_sel = m1_sel;
      end
      default: ;
    endcase
  end

  always_comb begin
    m0_dat_r = '0; m0_ack = 1'b0; m0_err = 1'b0;
    if (m0_bound0) begin
      m0_dat_r = s0_dat_r; m0_ack = s0_ack; m0_err = s0_err;
    end else if (m0_bound1) begin
      m0_dat_r = s1_dat_r; m0_ack = s1_ack; m0_err = s1_err;
    end else begin
      m0_err = err0_q;
    end
  end

  always_comb begin
    m1_dat_r = '0; m1_ack = 1'b0; m1_err = 1'b0;
    if (m1_bound0) begin
      m1_dat_r = s0_dat_r; m1_ack = s0_ack; m1_err = s0_err;
    end else if (m1_bound1) begin
      m1_dat_r = s1_dat_r; m1_ack = s1_ack; m1_err = s1_err;
    end else begin
      m1_err = err1_q;
    end
  end

endmodule

// File: tb/tb_wb_ic_2x2.sv
// Directed bench for wb_ic_2x2: decode, boundaries, arbitration, concurrency, reset.
module tb_wb_ic_2x2;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr, m0_dat_w, m0_dat_r, m1_adr, m1_dat_w, m1_dat_r;
  logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
  logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
  logic [3:0]  m0_sel, m1_sel, s0_sel, s1_sel;
  logic [31:0] s0_adr, s0_dat_w, s0_dat_r, s1_adr, s1_dat_w, s1_dat_r;
  logic        s0_cyc, s0_stb, s0_we, s0_ack, s0_err;
  logic        s1_cyc, s1_stb, s1_we, s1_ack, s1_err;

  logic        s0_ack_en, s1_ack_en;
  logic [31:0] s1_rdata;
  logic [31:0] mem [16];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  wb_ic_2x2 dut (
    .clk(clk), .rst(rst),
    .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r), .m0_cyc(m0_cyc),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r), .m1_cyc(m1_cyc),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_err(m1_err),
    .s0_adr(s0_adr), .s0_dat_w(s0_dat_w), .s0_dat_r(s0_dat_r), .s0_cyc(s0_cyc),
    .s0_stb(s0_stb), .s0_we(s0_we), .s0_sel(s0_sel), .s0_ack(s0_ack), .s0_err(s0_err),
    .s1_adr(s1_adr), .s1_dat_w(s1_dat_w), .s1_dat_r(s1_dat_r), .s1_cyc(s1_cyc),
    .s1_stb(s1_stb), .s1_we(s1_we), .s1_sel(s1_sel), .s1_ack(s1_ack), .s1_err(s1_err)
  );

  // Zero-wait slaves: s0 is a small RAM, s1 returns s1_rdata.
  assign s0_ack   = s0_cyc & s0_stb & s0_ack_en;
  assign s0_err   = 1'b0;
  assign s0_dat_r = mem[s0_adr[5:2]];
  assign s1_ack   = s1_cyc & s1_stb & s1_ack_en;
  assign s1_err   = 1'b0;
  assign s1_dat_r = s1_rdata;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + i;
    end else if (s0_cyc && s0_stb && s0_we && s0_ack) begin
      mem[s0_adr[5:2]] <= s0_dat_w;
    end
  end

  task automatic set_m0(input logic cyc, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat);
    m0_cyc = cyc; m0_stb = cyc; m0_we = we; m0_adr = adr; m0_dat_w = dat; m0_sel = 4'hf;
  endtask

  task automatic set_m1(input logic cyc, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat);
    m1_cyc = cyc; m1_stb = cyc; m1_we = we; m1_adr = adr; m1_dat_w = dat; m1_sel = 4'hf;
  endtask

  task automatic next_drive;
    @(posedge clk); #1;
  endtask

  // Drop both masters and let the grants fall back to idle.
  task automatic release_all;
    next_drive();
    set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
    next_drive();
    next_drive();
  endtask

  task automatic test_reset;
    rst = 1'b1; s0_ack_en = 1'b1; s1_ack_en = 1'b1; s1_rdata = 32'h0;
    set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s0_cyc, s0_stb, s1_cyc, s1_stb, m0_ack, m0_err, m1_ack, m1_err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 00000000",
               {s0_cyc, s0_stb, s1_cyc, s1_stb, m0_ack, m0_err, m1_ack, m1_err});
    end
    next_drive();
    rst = 1'b0;
    next_drive();
  endtask

  task automatic test_s0_decode;
    set_m0(1, 1, 32'h0000_0100, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++;
    if (s0_cyc !== 1'b0) begin errors++; $display("FAIL s0_latency got %b exp 0", s0_cyc); end
    @(negedge clk);
    checks++;
    if ({s0_cyc, s0_stb, s0_we, s1_cyc, m0_ack} !== 5'b11101) begin
      errors++; $display("FAIL s0_write_ctl got %b exp 11101", {s0_cyc, s0_stb, s0_we, s1_cyc, m0_ack});
    end
    checks++;
    if ({s0_adr, s0_dat_w} !== {32'h0000_0100, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL s0_write_fwd got %h %h exp 00000100 deadbeef", s0_adr, s0_dat_w);
    end
    next_drive();
    set_m0(0, 0, 0, 0);
    next_drive();
    set_m0(1, 0, 32'h0000_0100, 32'h0);
    @(negedge clk); @(negedge clk);
    checks++;
    if ({m0_ack, m0_dat_r} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL s0_readback got %b %h exp 1 deadbeef", m0_ack, m0_dat_r);
    end
    release_all();
  endtask

  task automatic test_s1_decode;
    s1_rdata = 32'h1234_5678;
    set_m1(1, 0, 32'h1000_0004, 32'h0);
    @(negedge clk);
    checks++;
    if ({s0_cyc, s1_cyc} !== 2'b00) begin errors++; $display("FAIL s1_latency got %b exp 00", {s0_cyc, s1_cyc}); end
    @(negedge clk);
    checks++;
    if ({s0_cyc, s1_cyc, s1_adr, m1_ack, m1_dat_r} !== {2'b01, 32'h1000_0004, 1'b1, 32'h1234_5678}) begin
      errors++; $display("FAIL s1_read got %b %b %h %b %h exp 0 1 10000004 1 12345678",
                         s0_cyc, s1_cyc, s1_adr, m1_ack, m1_dat_r);
    end
    release_all();
  endtask

  task automatic test_boundaries;
    set_m0(1, 0, 32'h0000_1fff, 32'h0);
    @(negedge clk); @(negedge clk);
    checks++;
    if ({s0_cyc, s1_cyc, m0_ack, m0_err} !== 4'b1010) begin
      errors++; $display("FAIL bnd_s0_top got %b exp 1010", {s0_cyc, s1_cyc, m0_ack, m0_err});
    end
    release_all();

    set_m0(1, 0, 32'h0000_2000, 32'h0);
    @(negedge clk);
    checks++;
    if (m0_err !== 1'b0) begin errors++; $display("FAIL bnd_err_early got %b exp 0", m0_err); end
    @(negedge clk);
    checks++;
    if ({s0_cyc, s1_cyc, m0_ack, m0_err} !== 4'b0001) begin
      errors++; $display("FAIL bnd_s0_past got %b exp 0001", {s0_cyc, s1_cyc, m0_ack, m0_err});
    end
    @(negedge clk);
    checks++;
    if (m0_err !== 1'b0) begin errors++; $display("FAIL bnd_err_gap got %b exp 0", m0_err); end
    @(negedge clk);
    checks++;
    if (m0_err !== 1'b1) begin errors++; $display("FAIL bnd_err_repeat got %b exp 1", m0_err); end
    release_all();

    s1_rdata = 32'h5555_AAAA;
    set_m0(1, 0, 32'h1fff_ffff, 32'h0);
    @(negedge clk); @(negedge clk);
    checks++;
    if ({s0_cyc, s1_cyc, m0_ack, m0_err, m0_dat_r} !== {4'b0110, 32'h5555_AAAA}) begin
      errors++; $display("FAIL bnd_s1_top got %b %h exp 0110 5555aaaa", {s0_cyc, s1_cyc, m0_ack, m0_err}, m0_dat_r);
    end
    release_all();

    set_m0(1, 0, 32'h2000_0000, 32'h0);
    @(negedge clk); @(negedge clk);
    checks++;
    if ({s0_cyc, s1_cyc, m0_ack, m0_err} !== 4'b0001) begin
      errors++; $display("FAIL bnd_s1_past got %b exp 0001", {s0_cyc, s1_cyc, m0_ack, m0_err});
    end
    release_all();

    set_m1(1, 0, 32'h0fff_ffff, 32'h0);
    @(negedge clk); @(negedge clk);
    checks++;
    if ({s0_cyc, s1_cyc, m1_ack, m1_err} !== 4'b0001) begin
      errors++; $display("FAIL bnd_s1_below got %b exp 0001", {s0_cyc, s1_cyc, m1_ack, m1_err});
    end
    release_all();
  endtask

  task automatic test_contention;
    bit seen;
    rst = 1'b1;
    next_drive();
    rst = 1'b0;
    next_drive();
    set_m0(1, 0, 32'h0000_0010, 32'h0);
    set_m1(1, 0, 32'h0000_0020, 32'h0);
    @(negedge clk); @(negedge clk);
    checks++;
    if ({s0_cyc, s0_adr, m0_ack, m1_ack} !== {1'b1, 32'h0000_0010, 2'b10}) begin
      errors++; $display("FAIL arb_first got %b %h %b %b exp 1 00000010 1 0", s0_cyc, s0_adr, m0_ack, m1_ack);
    end
    next_drive();
    set_m0(0, 0, 0, 0);
    next_drive();
    set_m0(1, 0, 32'h0000_0010, 32'h0);
    @(negedge clk);
    checks++;
    if (s0_cyc !== 1'b0) begin errors++; $display("FAIL arb_gap got %b exp 0", s0_cyc); end
    @(negedge clk);
    checks++;
    if ({s0_cyc, s0_adr, m0_ack, m1_ack} !== {1'b1, 32'h0000_0020, 2'b01}) begin
      errors++; $display("FAIL arb_round_robin got %b %h %b %b exp 1 00000020 0 1", s0_cyc, s0_adr, m0_ack, m1_ack);
    end
    next_drive();
    set_m1(0, 0, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (s0_cyc && s0_adr == 32'h0000_0010 && m0_ack) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL arb_m0_return got %b exp 1 within 4 cycles", seen); end
    release_all();
  endtask

  task automatic test_concurrency;
    s1_rdata = 32'hCAFE_F00D;
    s1_ack_en = 1'b0;
    set_m0(1, 0, 32'h1000_0008, 32'h0);
    set_m1(1, 0, 32'h0000_0044, 32'h0);
    @(negedge clk); @(negedge clk);
    checks++;
    if ({s0_cyc, s0_adr, s1_cyc, s1_adr} !== {1'b1, 32'h0000_0044, 1'b1, 32'h1000_0008}) begin
      errors++; $display("FAIL conc_slaves got %b %h %b %h exp 1 00000044 1 10000008", s0_cyc, s0_adr, s1_cyc, s1_adr);
    end
    checks++;
    if ({m1_ack, m1_dat_r, m0_ack} !== {1'b1, 32'hA000_0001, 1'b0}) begin
      errors++; $display("FAIL conc_indep_ack got %b %h %b exp 1 a0000001 0", m1_ack, m1_dat_r, m0_ack);
    end
    s1_ack_en = 1'b1;
    #1;
    checks++;
    if ({m0_ack, m0_dat_r} !== {1'b1, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL conc_m0_ack got %b %h exp 1 cafef00d", m0_ack, m0_dat_r);
    end
    release_all();
  endtask

  task automatic test_reset_mid;
    set_m0(1, 1, 32'h0000_0080, 32'h1111_2222);
    @(negedge clk); @(negedge clk);
    checks++;
    if ({s0_cyc, m0_ack} !== 2'b11) begin errors++; $display("FAIL rstmid_before got %b exp 11", {s0_cyc, m0_ack}); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({s0_cyc, s0_stb, m0_ack, m0_err} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_abort got %b exp 0000", {s0_cyc, s0_stb, m0_ack, m0_err});
    end
    next_drive();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({s0_cyc, m0_ack} !== 2'b00) begin errors++; $display("FAIL rstmid_idle got %b exp 00", {s0_cyc, m0_ack}); end
    @(negedge clk);
    checks++;
    if ({s0_cyc, m0_ack} !== 2'b11) begin errors++; $display("FAIL rstmid_regrant got %b exp 11", {s0_cyc, m0_ack}); end
    release_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_s0_decode();
    test_s1_decode();
    test_boundaries();
    test_contention();
    test_concurrency();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_ic_2x2.md
Name: wb_ic_2x2

Overview:
Two-master, two-slave Wishbone classic interconnect with address decode and per-slave arbitration. It sits between bus masters (test BFM, peripheral subsystem DMA port) and bus slaves (SRAM, peripheral subsystem register port). Both masters may proceed concurrently when they target different slaves. Accesses to unmapped addresses are terminated with an error.

Parameters:
WB_ADDR_WIDTH, 32, address bus width
WB_DATA_WIDTH, 32, data bus width; select width = WB_DATA_WIDTH/8
SLAVE0_ADDR_BASE, 'h0000_0000, first address decoded to slave 0
SLAVE0_ADDR_LIMIT, 'h0000_1fff, last address (inclusive) decoded to slave 0
SLAVE1_ADDR_BASE, 'h1000_0000, first address decoded to slave 1
SLAVE1_ADDR_LIMIT, 'h1fff_ffff, last address (inclusive) decoded to slave 1

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
mN_adr  in  WB_ADDR_WIDTH  master N address (N=0,1)
mN_dat_w  in  WB_DATA_WIDTH  master N write data
mN_dat_r  out  WB_DATA_WIDTH  master N read data
mN_cyc, mN_stb, mN_we  in  1  master N cycle, strobe, write-enable
mN_sel  in  WB_DATA_WIDTH/8  master N byte selects
mN_ack, mN_err  out  1  master N acknowledge, error
sK_adr  out  WB_ADDR_WIDTH  slave K address (K=0,1)
sK_dat_w  out  WB_DATA_WIDTH  slave K write data
sK_dat_r  in  WB_DATA_WIDTH  slave K read data
sK_cyc, sK_stb, sK_we  out  1  slave K cycle, strobe, write-enable
sK_sel  out  WB_DATA_WIDTH/8  slave K byte selects
sK_ack, sK_err  in  1  slave K acknowledge, error

Behaviour:
- Decode: slave K is hit when BASE_K <= adr <= LIMIT_K (unsigned, inclusive). Slave 0 wins if ranges overlap. No hit means unmapped.
- Request: master N requests slave K when mN_cyc & mN_stb & hit(K).
- Each slave has a registered grant state with values IDLE, M0 and M1.
  - IDLE -> Mx on the clock edge after mx requests. When both masters request, the tie-break is round-robin: the master not served last wins. After reset, m0 has priority.
  - Mx -> IDLE on the edge where mx_cyc is low. The grant is held for the whole cyc, including burst/locked sequences and stb gaps.
- Forwarding while slave K is granted to Mx:
  - sK_adr/dat_w/we/sel/cyc/stb = mx signals.
  - mx_dat_r = sK_dat_r, mx_ack = sK_ack, mx_err = sK_err (combinational pass-through).
- Idle slaves: sK_cyc = sK_stb = 0. Other sK outputs are 0.
- Masters that are neither granted nor in an error response: ack = err = 0, dat_r = 0. A requesting but ungranted master simply waits.
- Minimum latency: a request in cycle n is visible at the slave in cycle n+1 (one registered grant cycle).
- Unmapped access: mN_err is asserted in the cycle after the request is sampled, for exactly one cycle. If stb stays high, err is re-asserted every second cycle. mN_ack stays 0 and no slave is driven.
- Concurrency: m0->s0 and m1->s1, or m0->s1 and m1->s0, proceed in parallel with no interaction.
- A master cannot hold two slaves at once. While its cyc is high it stays bound to the slave it was granted.
- Reset (async assert, sync release):
  - All grants become IDLE; round-robin pointer favours m0.
  - All sK_cyc/stb = 0 and mN_ack/err = 0.
  - Reset mid-transfer aborts the transfer immediately.
- Target size: 150-300 lines RTL.

Test Plan:
- Basic decode, s0: m0 writes 0xDEADBEEF to 0x0000_0100 then reads it back. Expect s0_cyc/stb high from the cycle after the request, s1 untouched, and m0_dat_r = 0xDEADBEEF on m0_ack.
- Basic decode, s1: m1 reads 0x1000_0004 while s1 drives 0x12345678. Expect m1_dat_r = 0x12345678 with m1_ack, and s0_cyc = 0 throughout.
- Upper boundaries: address 0x0000_1fff goes to s0; address 0x0000_2000 gives m0_err one cycle later with no slave cycle; address 0x1fff_ffff goes to s1; address 0x2000_0000 gives err.
- Contention: m0 and m1 request s0 in the same cycle after reset. Expect m0 granted first; m1 granted the cycle after m0_cyc drops. On the next simultaneous contention m1 wins (round-robin).
- Concurrency: m0->s1 and m1->s0 in the same cycle. Expect both slaves active in cycle n+1 with independent acks.
- Reset mid-operation: assert rst while m0 holds s0 with ack pending. Expect s0_cyc = 0 and m0_ack = 0 immediately, and the grant IDLE after rst release.
